lcd_timing_rx: RTL and testbench

- Receive end of the parallel RGB565 LCD timing interface: consumes HS/VS/DE/data as driven by the display timing generator or an equivalent source.
- Recovers pixel coordinates and checks frame geometry against the expected active size.
- Forwards pixels to the frame-buffer write side only once the stream is locked.
- Used for loopback self-check of the display path and for capturing external timing-compatible sources into SDRAM.

---
 rtl/lcd_timing_rx.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_timing_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_rx.sv
`default_nettype none
//============================================================================
// Module   : lcd_timing_rx
// Purpose  : RGB565 LCD timing receiver. Recovers pixel coordinates, checks
//            frame geometry, forwards pixels once locked.
//            Define LCD_RX_GEOM_EN to add meas_htotal / meas_vtotal.
// Revision : 1.0  initial release
//============================================================================
module lcd_timing_rx #(
  parameter logic [11:0] H_DISP      = 12'd480,
  parameter logic [11:0] V_DISP      = 12'd272,
  parameter logic [3:0]  LOCK_FRAMES = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic [15:0] vid_data,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [15:0] pix_data,
  output logic        frame_start,
  output logic        locked,
`ifdef LCD_RX_GEOM_EN
  output logic [11:0] meas_htotal,
  output logic [11:0] meas_vtotal,
`endif
  output logic        frame_err
);

  localparam logic [11:0] C_SAT = 12'hFFF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  logic        r1_hs, r1_vs, r1_de;
  logic [15:0] r1_data;
  logic        r2_hs, r2_vs, r2_de;
  logic [11:0] r_xcnt, r_ycnt;
  logic        r_bad_frame, r_de_in_vs;
  logic [3:0]  r_good_cnt;

  logic        w_de_rise, w_de_fall, w_vs_fall;
  logic [11:0] w_x_cur, w_x_next, w_y_cur, w_y_inc, w_y_end;
  logic        w_line_bad, w_frame_bad, w_lock_next;
  logic [3:0]  w_good_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_hs   <= 1'b0;
      r1_vs   <= 1'b0;
      r1_de   <= 1'b0;
      r1_data <= 16'd0;
      r2_hs   <= 1'b0;
      r2_vs   <= 1'b0;
      r2_de   <= 1'b0;
    end else begin
      r1_hs   <= vid_hs;
      r1_vs   <= vid_vs;
      r1_de   <= vid_de;
      r1_data <= vid_data;
      r2_hs   <= r1_hs;
      r2_vs   <= r1_vs;
      r2_de   <= r1_de;
    end
  end

  assign w_de_rise  = r1_de & ~r2_de;
  assign w_de_fall  = ~r1_de & r2_de;
  assign w_vs_fall  = ~r1_vs & r2_vs;

  // Coordinates of the pixel currently in r1; a new line/frame restarts at 0.
  assign w_x_cur    = w_de_rise ? 12'd0 : r_xcnt;
  assign w_x_next   = (w_x_cur == C_SAT) ? C_SAT : w_x_cur + 12'd1;
  assign w_y_cur    = w_vs_fall ? 12'd0 : r_ycnt;
  assign w_y_inc    = (r_ycnt == C_SAT) ? C_SAT : r_ycnt + 12'd1;

  // A line ending together with VS fall still belongs to the ending frame.
  assign w_line_bad  = w_de_fall & (r_xcnt != H_DISP);
  assign w_y_end     = w_de_fall ? w_y_inc : r_ycnt;
  assign w_frame_bad = r_bad_frame | w_line_bad | (w_y_end != V_DISP) | r_de_in_vs;
  assign w_good_inc  = r_good_cnt + 4'd1;

  assign w_lock_next = w_vs_fall
                     ? (((r_state == LOCKED) && !w_frame_bad) ||
                        ((r_state == TRACK) && !w_frame_bad && (w_good_inc >= LOCK_FRAMES)))
                     : (r_state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xcnt      <= 12'd0;
      r_ycnt      <= 12'd0;
      r_bad_frame <= 1'b0;
      r_de_in_vs  <= 1'b0;
    end else begin
      if (r1_de)
        r_xcnt <= w_x_next;
      if (w_vs_fall)
        r_ycnt <= 12'd0;
      else if (w_de_fall)
        r_ycnt <= w_y_inc;
      if (w_vs_fall) begin
        r_bad_frame <= 1'b0;
        r_de_in_vs  <= r1_de;
      end else begin
        r_bad_frame <= r_bad_frame | w_line_bad;
        r_de_in_vs  <= r_de_in_vs | (r1_de & ~r1_vs);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      pix_data    <= 16'd0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= r1_de & w_lock_next;
      pix_x       <= w_x_cur;
      pix_y       <= w_y_cur;
      pix_data    <= r1_data;
      frame_start <= w_vs_fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEARCH;
      r_good_cnt <= 4'd0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      locked    <= w_lock_next;
      case (r_state)
        SEARCH: begin
          if (w_vs_fall) begin
            r_state    <= TRACK;
            r_good_cnt <= 4'd0;
          end
        end
        TRACK: begin
          if (w_vs_fall) begin
            if (w_frame_bad) begin
              r_good_cnt <= 4'd0;
              frame_err  <= 1'b1;
            end else if (w_good_inc >= LOCK_FRAMES) begin
              r_state    <= LOCKED;
              r_good_cnt <= 4'd0;
            end else begin
              r_good_cnt <= w_good_inc;
            end
          end
        end
        LOCKED: begin
          if (w_vs_fall && w_frame_bad) begin
            r_state    <= TRACK;
            r_good_cnt <= 4'd0;
            frame_err  <= 1'b1;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

`ifdef LCD_RX_GEOM_EN
  logic        w_hs_fall;
  logic [11:0] r_hcyc, r_hper, r_vcnt;

  assign w_hs_fall = ~r1_hs & r2_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcyc      <= 12'd0;
      r_hper      <= 12'd0;
      r_vcnt      <= 12'd0;
      meas_htotal <= 12'd0;
      meas_vtotal <= 12'd0;
    end else begin
      if (w_hs_fall) begin
        r_hcyc <= 12'd1;
        r_hper <= r_hcyc;
      end else if (r_hcyc != C_SAT) begin
        r_hcyc <= r_hcyc + 12'd1;
      end
      // An HS fall coincident with VS fall opens the first line of the new frame.
      if (w_vs_fall) begin
        meas_vtotal <= r_vcnt;
        meas_htotal <= w_hs_fall ? r_hcyc : r_hper;
        r_vcnt      <= w_hs_fall ? 12'd1 : 12'd0;
      end else if (w_hs_fall && (r_vcnt != C_SAT)) begin
        r_vcnt <= r_vcnt + 12'd1;
      end
    end
  end
`else
  logic w_unused_hs;
  assign w_unused_hs = r1_hs ^ r2_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_rx.sv
`default_nettype none
// Directed testbench for lcd_timing_rx with H_DISP=8, V_DISP=4, LOCK_FRAMES=2,
// H_TOTAL=16, V_TOTAL=8.
module tb_lcd_timing_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vid_hs, vid_vs, vid_de;
  logic [15:0] vid_data;
  logic        pix_valid, frame_start, locked, frame_err;
  logic [11:0] pix_x, pix_y;
  logic [15:0] pix_data;
`ifdef LCD_RX_GEOM_EN
  logic [11:0] meas_htotal, meas_vtotal;
`endif

  always #5 clk = ~clk;

  lcd_timing_rx #(
    .H_DISP(12'd8), .V_DISP(12'd4), .LOCK_FRAMES(4'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked),
`ifdef LCD_RX_GEOM_EN
    .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal),
`endif
    .frame_err(frame_err)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  int fs_cnt = 0, fe_cnt = 0, pv_cnt = 0;
  int fs_last_cyc = -1, fe_last_cyc = -1, lock_rise_cyc = -1, unlock_cyc = -1;
  int pv_first_cyc = -1;
  logic [11:0] first_x = 12'd0, first_y = 12'd0, last_x = 12'd0, last_y = 12'd0;
  logic [15:0] first_data = 16'd0;
  logic seen_fs = 1'b0;
  logic locked_q = 1'b0;

  int de_first_cyc = 0;
  logic [15:0] de_first_data = 16'd0;
  logic [3:0] tag = 4'd0;
  int b_fs, b_fe, b_pv;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation counters; tests compare deltas against their own snapshots.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_last_cyc = cyc;
      seen_fs = 1'b1;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_last_cyc = cyc;
    end
    if (pix_valid) begin
      if (seen_fs) begin
        first_x = pix_x;
        first_y = pix_y;
        first_data = pix_data;
        pv_first_cyc = cyc;
        seen_fs = 1'b0;
      end
      pv_cnt++;
      last_x = pix_x;
      last_y = pix_y;
    end
    if (locked && !locked_q) lock_rise_cyc = cyc;
    if (!locked && locked_q) unlock_cyc = cyc;
    locked_q = locked;
  end

  task automatic snap;
    b_fs = fs_cnt;
    b_fe = fe_cnt;
    b_pv = pv_cnt;
  endtask

  // One frame: VS low for vs_lines lines, n_act active lines from line 2,
  // active line index bad_line gets bad_len pixels; stops after stop_at cycles.
  task automatic send_frame(input int n_act, input int vs_lines, input int bad_line,
                            input int bad_len, input int stop_at);
    int len;
    logic [7:0] cb;
    logic [3:0] lb;
    tag = tag + 4'd1;
    for (int ln = 0; ln < 8; ln++) begin
      for (int c = 0; c < 16; c++) begin
        if (ln * 16 + c >= stop_at) return;
        len = (ln - 2 == bad_line) ? bad_len : 8;
        cb = c[7:0];
        lb = ln[3:0];
        vid_hs = (c >= 2);
        vid_vs = (ln >= vs_lines);
        vid_de = (ln >= 2) && (ln < 2 + n_act) && (c >= 4) && (c < 4 + len);
        vid_data = {tag, lb, cb};
        if (ln == 2 && c == 4) begin
          de_first_cyc = cyc;
          de_first_data = vid_data;
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_good;
    send_frame(4, 1, -1, 8, 128);
  endtask

  task automatic send_idle_lines(input int n);
    for (int i = 0; i < n * 16; i++) begin
      vid_hs = ((i % 16) >= 2);
      vid_vs = 1'b1;
      vid_de = 1'b0;
      vid_data = 16'd0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid: got %b expected 0", pix_valid); else passed++;
    checks++; if (pix_x !== 12'd0) $display("FAIL rst_pix_x: got %0d expected 0", pix_x); else passed++;
    checks++; if (pix_y !== 12'd0) $display("FAIL rst_pix_y: got %0d expected 0", pix_y); else passed++;
    checks++; if (pix_data !== 16'd0) $display("FAIL rst_pix_data: got %h expected 0", pix_data); else passed++;
    checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b expected 0", frame_start); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b expected 0", locked); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b expected 0", frame_err); else passed++;
    rst_n = 1'b1;
    snap();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (fs_cnt - b_fs !== 0) $display("FAIL idle_frame_start: got %0d expected 0", fs_cnt - b_fs); else passed++;
  endtask

  task automatic test_lock;
    snap();
    send_good();
    send_good();
    checks++; if (locked !== 1'b0) $display("FAIL lock_early: got %b expected 0", locked); else passed++;
    checks++; if (pv_cnt - b_pv !== 0) $display("FAIL lock_pv_early: got %0d expected 0", pv_cnt - b_pv); else passed++;
    send_good();
    checks++; if (locked !== 1'b1) $display("FAIL lock_locked: got %b expected 1", locked); else passed++;
    checks++; if (lock_rise_cyc !== fs_last_cyc) $display("FAIL lock_edge: got cycle %0d expected %0d", lock_rise_cyc, fs_last_cyc); else passed++;
    checks++; if (fs_cnt - b_fs !== 3) $display("FAIL lock_fs_cnt: got %0d expected 3", fs_cnt - b_fs); else passed++;
    checks++; if (fe_cnt - b_fe !== 0) $display("FAIL lock_fe_cnt: got %0d expected 0", fe_cnt - b_fe); else passed++;
    checks++; if (pv_cnt - b_pv !== 32) $display("FAIL lock_pv_cnt: got %0d expected 32", pv_cnt - b_pv); else passed++;
    checks++; if (first_x !== 12'd0 || first_y !== 12'd0) $display("FAIL lock_first_xy: got (%0d,%0d) expected (0,0)", first_x, first_y); else passed++;
    checks++; if (first_data !== de_first_data) $display("FAIL lock_first_data: got %h expected %h", first_data, de_first_data); else passed++;
    checks++; if (pv_first_cyc - de_first_cyc !== 2) $display("FAIL lock_latency: got %0d expected 2", pv_first_cyc - de_first_cyc); else passed++;
    checks++; if (last_x !== 12'd7 || last_y !== 12'd3) $display("FAIL lock_last_xy: got (%0d,%0d) expected (7,3)", last_x, last_y); else passed++;
  endtask

  task automatic test_bad_line;
    snap();
    send_frame(4, 1, 2, 7, 128);
    checks++; if (pv_cnt - b_pv !== 31) $display("FAIL badline_pv_cnt: got %0d expected 31", pv_cnt - b_pv); else passed++;
    checks++; if (fe_cnt - b_fe !== 0) $display("FAIL badline_fe_early: got %0d expected 0", fe_cnt - b_fe); else passed++;
    send_good();
    checks++; if (fe_cnt - b_fe !== 1) $display("FAIL badline_fe_cnt: got %0d expected 1", fe_cnt - b_fe); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL badline_unlock: got %b expected 0", locked); else passed++;
    checks++; if (unlock_cyc !== fe_last_cyc || fe_last_cyc !== fs_last_cyc) $display("FAIL badline_err_timing: got unlock %0d err %0d expected fs %0d", unlock_cyc, fe_last_cyc, fs_last_cyc); else passed++;
    send_good();
    checks++; if (locked !== 1'b0) $display("FAIL badline_relock_early: got %b expected 0", locked); else passed++;
    send_good();
    checks++; if (locked !== 1'b1) $display("FAIL badline_relock: got %b expected 1", locked); else passed++;
  endtask

  task automatic test_bad_height;
    snap();
    send_frame(5, 1, -1, 8, 128);
    send_good();
    checks++; if (fe_cnt - b_fe !== 1) $display("FAIL height_fe_cnt: got %0d expected 1", fe_cnt - b_fe); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL height_unlock: got %b expected 0", locked); else passed++;
    send_frame(5, 1, -1, 8, 128);
    send_good();
    send_good();
    checks++; if (fe_cnt - b_fe !== 2) $display("FAIL height_fe_track: got %0d expected 2", fe_cnt - b_fe); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL height_goodcnt_reset: got %b expected 0", locked); else passed++;
    send_good();
    checks++; if (locked !== 1'b1) $display("FAIL height_relock: got %b expected 1", locked); else passed++;
  endtask

  task automatic test_de_in_vs;
    snap();
    send_frame(4, 3, -1, 8, 128);
    send_good();
    checks++; if (fe_cnt - b_fe !== 1) $display("FAIL devs_fe_cnt: got %0d expected 1", fe_cnt - b_fe); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL devs_unlock: got %b expected 0", locked); else passed++;
    send_good();
    send_good();
    checks++; if (locked !== 1'b1) $display("FAIL devs_relock: got %b expected 1", locked); else passed++;
  endtask

  task automatic test_reset_mid;
    send_frame(4, 1, -1, 8, 56);
    checks++; if (pix_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b expected 1", pix_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (pix_valid !== 1'b0) $display("FAIL rmid_pix_valid: got %b expected 0", pix_valid); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL rmid_locked: got %b expected 0", locked); else passed++;
    checks++; if (pix_x !== 12'd0 || pix_y !== 12'd0) $display("FAIL rmid_xy: got (%0d,%0d) expected (0,0)", pix_x, pix_y); else passed++;
    checks++; if (pix_data !== 16'd0) $display("FAIL rmid_pix_data: got %h expected 0", pix_data); else passed++;
    checks++; if (frame_start !== 1'b0 || frame_err !== 1'b0) $display("FAIL rmid_pulses: got fs %b fe %b expected 0 0", frame_start, frame_err); else passed++;
    vid_hs = 1'b1;
    vid_vs = 1'b1;
    vid_de = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_idle_lines(2);
    snap();
    send_good();
    send_good();
    checks++; if (pv_cnt - b_pv !== 0) $display("FAIL rmid_pv_early: got %0d expected 0", pv_cnt - b_pv); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL rmid_lock_early: got %b expected 0", locked); else passed++;
    send_good();
    checks++; if (locked !== 1'b1) $display("FAIL rmid_relock: got %b expected 1", locked); else passed++;
    checks++; if (pv_cnt - b_pv !== 32) $display("FAIL rmid_pv_cnt: got %0d expected 32", pv_cnt - b_pv); else passed++;
    checks++; if (fe_cnt - b_fe !== 0) $display("FAIL rmid_fe_cnt: got %0d expected 0", fe_cnt - b_fe); else passed++;
  endtask

`ifdef LCD_RX_GEOM_EN
  task automatic test_geom;
    checks++; if (meas_htotal !== 12'd16) $display("FAIL geom_htotal: got %0d expected 16", meas_htotal); else passed++;
    checks++; if (meas_vtotal !== 12'd8) $display("FAIL geom_vtotal: got %0d expected 8", meas_vtotal); else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    vid_hs = 1'b1;
    vid_vs = 1'b1;
    vid_de = 1'b0;
    vid_data = 16'd0;
    #1;
    test_reset();
    test_lock();
    test_bad_line();
    test_bad_height();
    test_de_in_vs();
    test_reset_mid();
`ifdef LCD_RX_GEOM_EN
    test_geom();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
